// File: rtl/sm_muldiv_pkg.sv
// Shared encodings for the schoolMIPS multiply/divide unit.
package sm_muldiv_pkg;

  // Operation select on the oper port
  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_DIVU  = 2'b01;
  localparam logic [1:0] MD_MULT  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  // R-type function codes handled by the unit (decoder side)
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  // Controller states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  function automatic logic md_is_div(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/sm_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide.
// Multiply: acc = {partial product, remaining multiplier bits}, opnd = multiplicand.
// Divide:   acc = {remainder, remaining dividend / quotient bits}, opnd = divisor.
module sm_muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Compute both candidate iterations and select by mode
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge       = (shifted >= {1'b0, opnd});
    // When ge holds the true difference is below opnd, so WIDTH bits suffice
    diff     = shifted[WIDTH-1:0] - opnd;
    acc_next = '0;
    if (is_div) begin
      acc_next = {(ge ? diff : shifted[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sm_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
module sm_muldiv
  import sm_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       oper,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hiWe,
  input  logic             loWe,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned   CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               sign_a;
  logic               sign_b;
  logic               dz_pend;
  logic               done_r;
  logic               div_zero_r;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;

  logic               in_sa;
  logic               in_sb;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  sm_muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc      (acc),
    .opnd     (opnd),
    .is_div   (is_div),
    .acc_next (acc_next)
  );

  // Operand signs and magnitudes at accept; |MIN| wraps to MIN, which is the intended value
  always_comb begin
    in_sa = md_is_signed(oper) & srcA[WIDTH-1];
    in_sb = md_is_signed(oper) & srcB[WIDTH-1];
    mag_a = in_sa ? -srcA : srcA;
    mag_b = in_sb ? -srcB : srcB;
  end

  // Sign fix-up of the raw magnitude result
  always_comb begin
    neg  = sign_a ^ sign_b;
    prod = neg ? -acc : acc;
    // Divide by zero yields an all-ones quotient that must not be negated
    quo  = (neg && !dz_pend) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    // Remainder follows the dividend; for divide by zero this restores srcA exactly
    rem  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
    fix_lo = is_div ? quo : prod[WIDTH-1:0];
  end

  // Controller, datapath registers and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      is_div     <= 1'b0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      dz_pend    <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      opnd       <= '0;
      acc        <= '0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_CALC;
            cnt        <= CNT_INIT;
            is_div     <= md_is_div(oper);
            sign_a     <= in_sa;
            sign_b     <= in_sb;
            dz_pend    <= md_is_div(oper) && (srcB == '0);
            div_zero_r <= 1'b0;
            acc        <= {{WIDTH{1'b0}}, (md_is_div(oper) ? mag_a : mag_b)};
            opnd       <= md_is_div(oper) ? mag_b : mag_a;
          end else begin
            if (hiWe) hi <= wd;
            if (loWe) lo <= wd;
          end
        end
        S_CALC: begin
          acc <= acc_next;
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - CW'(1);
        end
        S_FIX: begin
          hi         <= fix_hi;
          lo         <= fix_lo;
          div_zero_r <= dz_pend;
          done_r     <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign done    = done_r;
  assign divZero = div_zero_r;

endmodule

// File: tb/tb_sm_muldiv.sv
// Directed self-checking bench for sm_muldiv at WIDTH=32.
module tb_sm_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   oper = 2'b00;
  logic [W-1:0] srcA = '0;
  logic [W-1:0] srcB = '0;
  logic         hiWe = 1'b0;
  logic         loWe = 1'b0;
  logic [W-1:0] wd = '0;
  logic         busy;
  logic         done;
  logic         divZero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  sm_muldiv #(
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .oper    (oper),
    .srcA    (srcA),
    .srcB    (srcB),
    .hiWe    (hiWe),
    .loWe    (loWe),
    .wd      (wd),
    .busy    (busy),
    .done    (done),
    .divZero (divZero),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Launch one operation, optionally disturb it mid-CALC, and wait for done (bounded)
  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit we_at_start, input bit disturb,
                        input logic [W-1:0] hold_hi, input logic [W-1:0] hold_lo,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; oper = op; srcA = a; srcB = b;
    if (we_at_start) begin hiWe = 1'b1; loWe = 1'b1; wd = 32'h0000_7777; end
    @(posedge clk); #1;
    start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
    srcA = 32'hDEAD_BEEF; srcB = 32'h1357_9BDF; oper = ~op;
    check({name, "_dz_clear"}, 64'(divZero), 64'd0);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      if (disturb && lat == 5) begin
        start = 1'b1; hiWe = 1'b1; loWe = 1'b1; wd = 32'h0000_5555;
      end else begin
        start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
      end
      if (disturb && lat == 10) begin
        check({name, "_hold_hi"}, 64'(hi), 64'(hold_hi));
        check({name, "_hold_lo"}, 64'(lo), 64'(hold_lo));
      end
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
    start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                       input logic [W-1:0] exp_lo, input logic exp_dz,
                       input bit we_at_start, input bit disturb,
                       input logic [W-1:0] hold_hi, input logic [W-1:0] hold_lo);
    int lat;
    int bc;
    run_op(name, op, a, b, we_at_start, disturb, hold_hi, hold_lo, lat, bc);
    check({name, "_lat"}, 64'(lat), 64'd33);
    check({name, "_hi"}, 64'(hi), 64'(exp_hi));
    check({name, "_lo"}, 64'(lo), 64'(exp_lo));
    check({name, "_dz"}, 64'(divZero), 64'(exp_dz));
  endtask

  task automatic direct_write(input bit to_hi, input logic [W-1:0] data);
    @(negedge clk);
    hiWe = to_hi; loWe = !to_hi; wd = data;
    @(posedge clk); #1;
    hiWe = 1'b0; loWe = 1'b0;
  endtask

  initial begin
    int lat;
    int bc;

    // Reset values
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(divZero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MULTU max x max with latency, busy span and done pulse width
    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, '0, lat, bc);
    check("multu_max_lat", 64'(lat), 64'd33);
    check("multu_max_busy", 64'(bc), 64'd33);
    check("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_max_lo", 64'(lo), 64'h0000_0001);
    @(posedge clk); #1;
    check("done_drop", 64'(done), 64'd0);
    check("hi_after", 64'(hi), 64'hFFFF_FFFE);

    do_op("mult_n3x7", 2'b10, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0,
          1'b0, 1'b0, '0, '0);
    do_op("div_n7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0,
          1'b0, 1'b0, '0, '0);
    do_op("divu_100d7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 1'b0, '0, '0);
    do_op("divu_5d0", 2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, '0, '0);
    do_op("div_n5d0", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1,
          1'b0, 1'b0, '0, '0);
    do_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0,
          1'b0, 1'b0, '0, '0);

    // Direct writes in IDLE
    direct_write(1'b1, 32'h0000_1234);
    check("mthi", 64'(hi), 64'h0000_1234);
    direct_write(1'b0, 32'h0000_ABCD);
    check("mtlo", 64'(lo), 64'h0000_ABCD);
    check("mtlo_hi_kept", 64'(hi), 64'h0000_1234);

    // start and writes during CALC ignored; hi/lo held until FIX
    do_op("divu_dist", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 1'b1,
          32'h0000_1234, 32'h0000_ABCD);
    @(posedge clk); #1;
    check("dist_no_queue", 64'(busy), 64'd0);

    // Write presented together with start is dropped
    do_op("divu_we_start", 2'b01, 32'd47, 32'd5, 32'd2, 32'd9, 1'b0, 1'b1, 1'b0, '0, '0);

    // Asynchronous reset at CALC cycle 10
    @(negedge clk);
    start = 1'b1; oper = 2'b00; srcA = 32'hFFFF_FFFF; srcB = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("multu_6x7", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0, 1'b0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sm_muldiv.md
# sm_muldiv

Iterative multiply/divide unit for the schoolMIPS datapath. It adds MIPS MULT/MULTU/DIV/DIVU and the HI/LO result registers beside the single-cycle ALU. It is parametrised in operand width and takes one iteration per bit. The CPU starts an operation, stalls on `busy`, and reads `hi`/`lo` once `done` fires. MTHI/MTLO-style writes go straight into the result registers.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥ 4 and even.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only when `busy`=0.
- oper  in  2  operation: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- srcA  in  WIDTH  multiplicand / dividend.
- srcB  in  WIDTH  multiplier / divisor.
- hiWe  in  1  write `wd` into HI.
- loWe  in  1  write `wd` into LO.
- wd  in  WIDTH  direct write data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO have been updated by an operation.
- divZero  out  1  last completed divide had srcB=0; cleared by the next accepted start.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).

## Operation
- Reset: state IDLE; busy, done, divZero = 0; hi, lo, counter and all datapath registers = 0.
- States and transitions:
  - IDLE: start=1 → CALC.
  - CALC: counter expires → FIX.
  - FIX: → IDLE.
- Accept (IDLE, start=1):
  - Latch oper and the operand magnitudes. Signed modes use |x| modulo 2^WIDTH, and also latch both operand signs.
  - Load counter with WIDTH-1; clear divZero.
- CALC, multiply: shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- CALC, divide: restoring division, one quotient bit per cycle, WIDTH-bit remainder with an extra carry bit.
- CALC ends after exactly WIDTH cycles (counter reaches 0 → FIX).
- FIX, sign fix-up:
  - Product: negate the 2·WIDTH result if the operand signs differ.
  - Quotient: negate if the operand signs differ.
  - Remainder: takes the sign of the dividend.
- FIX, writeback: hi ← upper half/remainder, lo ← lower half/quotient; done=1 for the following cycle.
- Divide by zero (either divide mode): hi = srcA as given (unsigned value), lo = all ones, divZero=1. No extra cycles.
- Signed overflow (MIN / −1): lo = MIN, hi = 0. This is the natural magnitude result; no special case.
- Direct writes: hiWe/loWe take effect only in IDLE with start=0.
  - If start=1 in the same cycle, start wins and the write is dropped.
  - Writes during CALC/FIX are ignored.
- start while busy is ignored; it is not queued.
- hi/lo hold their previous values throughout CALC and change only at FIX or on a direct write.

## Timing
- Start accepted at edge E0; busy=1 after E0.
- CALC occupies edges E1..E_WIDTH; the FIX writeback is at edge E_WIDTH+1.
- After E_WIDTH+1: busy=0, done=1, and hi/lo/divZero are valid. done drops after E_WIDTH+2.
- Total latency is WIDTH+1 cycles (33 at WIDTH=32).
- A new start may be presented in the done cycle and is accepted at that edge.
- Operands need only be valid in the E0 cycle.
- Reset mid-operation (rst_n low at any point) forces the reset values at once. The next start after release behaves normally.
- Direct writes are visible on hi/lo one cycle after the write edge.

## Structure
- Add to the shared header `sm_cpu.vh`:
  - MD_* operation encodings (MULTU/DIVU/MULT/DIV).
  - Function codes F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_MTHI, F_MTLO.
  - State encodings for IDLE/CALC/FIX.
- One combinational sub-module is natural: `sm_muldiv_step`. It computes one shift-add or one restore-subtract iteration from (accumulator, operand, mode) and keeps the FSM module free of arithmetic.
- Counter width is $clog2(WIDTH).

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 cycles after the start edge; busy high for 33 cycles.
- MULT −3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 7 → lo=14, hi=2, divZero=0.
- DIVU 5 / 0 → lo=0xFFFFFFFF, hi=5, divZero=1.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Busy/write/reset interactions:
  - start re-pulsed and hiWe=1 (wd=0x1234) during CALC → both ignored; result as if absent.
  - hiWe in IDLE → hi=0x1234 next cycle.
  - rst_n low at CALC cycle 10 → busy=0, hi=lo=0.
  - A following MULTU 6×7 → lo=42.
